// File: rtl/cac_link_scheduler.sv
// Round-robin scheduler sharing one CAC coder/decoder TSV channel between two requesters.
// Words are sent as BLEN-bit chunks; each coded chunk is checked for FTF violations and decode mismatches.
module cac_link_scheduler #(
  parameter  int unsigned BLEN   = 3,
  parameter  int unsigned TSV_W  = 4,
  parameter  int unsigned CHUNKS = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned WORD_W = BLEN * CHUNKS
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sched_en,
  input  logic              cnt_clr,
  input  logic              req0_valid,
  input  logic              req1_valid,
  input  logic [WORD_W-1:0] req0_data,
  input  logic [WORD_W-1:0] req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic [BLEN-1:0]   coder_data,
  output logic              coder_en,
  input  logic [TSV_W-1:0]  tsv,
  input  logic [BLEN-1:0]   dec_data,
  output logic              busy,
  output logic              word_done,
  output logic              word_src,
  output logic              word_err,
  output logic [CNT_W-1:0]  ftf_count,
  output logic [CNT_W-1:0]  mis_count
);

  localparam int unsigned IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, SEND, CHECK, DONE} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic                src_q, src_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                acc_q, acc_d;
  logic [BLEN-1:0]     cd_q, cd_d;
  logic                ce_q, ce_d;
  logic                done_q, done_d;
  logic                wsrc_q, wsrc_d;
  logic                werr_q, werr_d;
  logic [CNT_W-1:0]    ftf_q, ftf_d;
  logic [CNT_W-1:0]    mis_q, mis_d;

  logic grant_any, grant_sel;
  logic ftf_hit, mis_hit;

  // Ready is combinational so the word is taken in the grant cycle; held low while in reset.
  always_comb begin
    grant_any  = reset_n && (state_q == IDLE) && sched_en && (req0_valid || req1_valid);
    grant_sel  = rr_q ? req1_valid : !req0_valid;
    req0_ready = grant_any && !grant_sel;
    req1_ready = grant_any && grant_sel;
  end

  // Odd lines must not fall below their lower neighbour, even lines must not rise above it.
  always_comb begin
    ftf_hit = 1'b0;
    for (int unsigned j = 1; j < TSV_W; j++) begin
      if ((j % 2) == 1) ftf_hit = ftf_hit | (!tsv[j] && tsv[j-1]);
      else              ftf_hit = ftf_hit | (tsv[j] && !tsv[j-1]);
    end
    mis_hit = (dec_data != cd_q);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    word_d  = word_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    cd_d    = cd_q;
    ce_d    = 1'b0;
    done_d  = 1'b0;
    wsrc_d  = wsrc_q;
    werr_d  = werr_q;
    ftf_d   = ftf_q;
    mis_d   = mis_q;

    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          src_d   = grant_sel;
          word_d  = grant_sel ? req1_data : req0_data;
          acc_d   = 1'b0;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: state_d = CHECK;
      CHECK: begin
        acc_d = acc_q | ftf_hit | mis_hit;
        if (idx_q == IDX_W'(CHUNKS - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          wsrc_d  = src_q;
          werr_d  = acc_d;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SEND;
        end
      end
      DONE: begin
        rr_d    = !src_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so the chunk is loaded on the edge that enters SEND.
    if (state_d == SEND) begin
      ce_d = 1'b1;
      cd_d = word_d[idx_d*BLEN +: BLEN];
    end

    if (cnt_clr) begin
      ftf_d = '0;
      mis_d = '0;
    end else if (state_q == CHECK) begin
      if (ftf_hit && (ftf_q != '1)) ftf_d = ftf_q + 1'b1;
      if (mis_hit && (mis_q != '1)) mis_d = mis_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      src_q   <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      cd_q    <= '0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      wsrc_q  <= 1'b0;
      werr_q  <= 1'b0;
      ftf_q   <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      cd_q    <= cd_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
      wsrc_q  <= wsrc_d;
      werr_q  <= werr_d;
      ftf_q   <= ftf_d;
      mis_q   <= mis_d;
    end
  end

  assign coder_data = cd_q;
  assign coder_en   = ce_q;
  assign busy       = (state_q != IDLE);
  assign word_done  = done_q;
  assign word_src   = wsrc_q;
  assign word_err   = werr_q;
  assign ftf_count  = ftf_q;
  assign mis_count  = mis_q;

endmodule

// File: tb/tb_cac_link_scheduler.sv
// Bench for cac_link_scheduler: table of single-word transfers, directed corner sequences,
// and random traffic checked by a transaction-level model with a simple FNS coder stand-in.
module tb_cac_link_scheduler;
  localparam int unsigned BLEN = 3, TSV_W = 4, CHUNKS = 4, CNT_W = 16, WORD_W = 12, SAT_W = 3;

  logic clock = 1'b0, reset_n = 1'b0, sched_en = 1'b0, cnt_clr = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WORD_W-1:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready, coder_en, busy, word_done, word_src, word_err;
  logic [BLEN-1:0] coder_data, dec_data;
  logic [TSV_W-1:0] tsv;
  logic [CNT_W-1:0] ftf_count, mis_count;
  logic s_r0, s_r1, s_ce, s_busy, s_done, s_src, s_err;
  logic [BLEN-1:0] s_cd;
  logic [SAT_W-1:0] s_ftf, s_mis;

  cac_link_scheduler #(.BLEN(BLEN), .TSV_W(TSV_W), .CHUNKS(CHUNKS), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .sched_en(sched_en), .cnt_clr(cnt_clr),
    .req0_valid(req0_valid), .req1_valid(req1_valid), .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready), .coder_data(coder_data), .coder_en(coder_en),
    .tsv(tsv), .dec_data(dec_data), .busy(busy), .word_done(word_done), .word_src(word_src),
    .word_err(word_err), .ftf_count(ftf_count), .mis_count(mis_count));

  // Narrow-counter copy sharing every input, used to reach saturation quickly.
  cac_link_scheduler #(.BLEN(BLEN), .TSV_W(TSV_W), .CHUNKS(CHUNKS), .CNT_W(SAT_W)) dut_sat (
    .clock(clock), .reset_n(reset_n), .sched_en(sched_en), .cnt_clr(cnt_clr),
    .req0_valid(req0_valid), .req1_valid(req1_valid), .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(s_r0), .req1_ready(s_r1), .coder_data(s_cd), .coder_en(s_ce),
    .tsv(tsv), .dec_data(dec_data), .busy(s_busy), .word_done(s_done), .word_src(s_src),
    .word_err(s_err), .ftf_count(s_ftf), .mis_count(s_mis));

  always #5 clock = ~clock;

  // FNS coder stand-in: the eight FTF-free 4-bit codewords in ascending order, indexed by value.
  logic [TSV_W-1:0] code_tab [8] = '{4'h0, 4'h2, 4'h3, 4'h8, 4'hA, 4'hB, 4'hE, 4'hF};
  logic [BLEN-1:0] coder_reg = '0;
  logic tsv_ovr = 1'b0, dec_bad = 1'b0;
  logic [TSV_W-1:0] tsv_ovr_val = '0;

  always @(posedge clock) if (coder_en) coder_reg <= coder_data;

  function automatic bit in_tab(input logic [TSV_W-1:0] cw);
    in_tab = 1'b0;
    for (int i = 0; i < 8; i++) if (code_tab[i] == cw) in_tab = 1'b1;
  endfunction

  function automatic logic [BLEN-1:0] decode(input logic [TSV_W-1:0] cw);
    decode = '0;
    for (int i = 0; i < 8; i++) if (code_tab[i] == cw) decode = 3'(i);
  endfunction

  assign tsv      = tsv_ovr ? tsv_ovr_val : code_tab[coder_reg];
  assign dec_data = decode(code_tab[coder_reg]) ^ {2'b00, dec_bad};

  int unsigned n_cmp = 0, n_mis = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: position within the word counted from the accept cycle.
  bit m_act = 0, m_rr = 0, m_src = 0, m_acc = 0, g_any, g_sel, ftf_now, mis_now, is_chk;
  int m_t = 0;
  int unsigned m_ftf = 0, m_mis = 0, m_sftf = 0, m_smis = 0, m_words = 0;
  logic [WORD_W-1:0] m_word = '0;
  logic [BLEN-1:0] m_cd = '0;

  always @(negedge clock) begin
    if (!reset_n) begin
      chk("rst_outs", 64'({req0_ready, req1_ready, coder_en, busy, word_done, word_src, word_err,
                           coder_data, ftf_count, mis_count}), 64'd0);
      chk("rst_outs_sat", 64'({s_r0, s_r1, s_ce, s_busy, s_done, s_src, s_err, s_cd, s_ftf, s_mis}), 64'd0);
      m_act = 0; m_rr = 0; m_cd = '0;
      m_ftf = 0; m_mis = 0; m_sftf = 0; m_smis = 0;
    end else begin
      is_chk = 0;
      chk("ftf_count", 64'(ftf_count), 64'(m_ftf));
      chk("mis_count", 64'(mis_count), 64'(m_mis));
      chk("sat_ftf", 64'(s_ftf), 64'(m_sftf));
      chk("sat_mis", 64'(s_mis), 64'(m_smis));
      if (!m_act) begin
        g_any = sched_en && (req0_valid || req1_valid);
        g_sel = m_rr ? req1_valid : !req0_valid;
        chk("ready", 64'({req0_ready, req1_ready}), g_any ? (g_sel ? 64'd1 : 64'd2) : 64'd0);
        chk("idle_quiet", 64'({coder_en, busy, word_done}), 64'd0);
        chk("coder_hold", 64'(coder_data), 64'(m_cd));
        if (g_any) begin
          m_act = 1; m_t = 0; m_src = g_sel; m_acc = 0;
          m_word = g_sel ? req1_data : req0_data;
        end
      end else begin
        m_t++;
        chk("ready_busy", 64'({req0_ready, req1_ready}), 64'd0);
        chk("busy", 64'(busy), 64'd1);
        if (m_t == 2 * CHUNKS + 1) begin
          chk("word_done", 64'({word_done, coder_en}), 64'd2);
          chk("word_src", 64'(word_src), 64'(m_src));
          chk("word_err", 64'(word_err), 64'(m_acc));
          m_rr = !m_src; m_act = 0; m_words++;
        end else if ((m_t % 2) == 1) begin
          m_cd = BLEN'(m_word >> (BLEN * ((m_t - 1) / 2)));
          chk("send_en", 64'({coder_en, word_done}), 64'd2);
          chk("send_data", 64'(coder_data), 64'(m_cd));
        end else begin
          is_chk = 1;
          ftf_now = !in_tab(tsv);
          mis_now = (dec_data != m_cd);
          m_acc = m_acc | ftf_now | mis_now;
          chk("check_quiet", 64'({coder_en, word_done}), 64'd0);
          chk("check_hold", 64'(coder_data), 64'(m_cd));
        end
      end
      if (cnt_clr) begin
        m_ftf = 0; m_mis = 0; m_sftf = 0; m_smis = 0;
      end else if (is_chk) begin
        if (ftf_now) begin
          if (m_ftf < 65535) m_ftf++;
          if (m_sftf < 7) m_sftf++;
        end
        if (mis_now) begin
          if (m_mis < 65535) m_mis++;
          if (m_smis < 7) m_smis++;
        end
      end
    end
  end

  typedef struct {
    bit ok; int wait_c; int lat; bit src; bit err;
    logic [WORD_W-1:0] chunks; logic [15:0] mis_start, mis_end, mis_after_clr, ftf_end;
  } res_t;

  // Called at posedge+1 of an idle cycle; returns at posedge+1 of the cycle after word_done.
  task automatic send_word(input bit which, input logic [WORD_W-1:0] data, input bit corrupt,
                           input int ftf_at, input int clr_at, output res_t r);
    bit acc;
    int k;
    r = '{default: 0};
    acc = 0;
    dec_bad = corrupt;
    if (which) begin req1_valid = 1; req1_data = data; end
    else       begin req0_valid = 1; req0_data = data; end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clock);
      if (i == 0) r.mis_start = mis_count;
      if (which ? req1_ready : req0_ready) begin acc = 1; r.wait_c = i; end
      @(posedge clock); #1;
    end
    req0_valid = 0; req1_valid = 0;
    if (!acc) begin
      chk("accept_timeout", 64'd0, 64'd1);
      dec_bad = 0;
      return;
    end
    k = 1;
    while (k <= 30 && !r.ok) begin
      tsv_ovr = (ftf_at > 0) && (k == 2 * ftf_at);
      tsv_ovr_val = 4'b0101;
      cnt_clr = (clr_at > 0) && (k == 2 * clr_at);
      @(negedge clock);
      if (coder_en) r.chunks = {coder_data, r.chunks[WORD_W-1:BLEN]};
      if (clr_at > 0 && k == 2 * clr_at + 1) r.mis_after_clr = mis_count;
      if (word_done) begin
        r.ok = 1; r.lat = k; r.src = word_src; r.err = word_err;
        r.mis_end = mis_count; r.ftf_end = ftf_count;
      end
      @(posedge clock); #1;
      k++;
    end
    tsv_ovr = 0; cnt_clr = 0; dec_bad = 0;
    if (!r.ok) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic clear_counts();
    cnt_clr = 1; @(posedge clock); #1; cnt_clr = 0;
  endtask

  typedef struct {
    bit which; logic [WORD_W-1:0] data; bit corrupt;
    logic [WORD_W-1:0] exp_chunks; bit exp_err; int exp_mis_d;
  } vec_t;

  vec_t vecs [6];
  res_t r;
  int gsrc [4], rcyc [4], dsrc [4], dcyc [4];
  int ng, nd;

  initial begin
    vecs[0] = '{0, 12'h321, 0, {3'd1, 3'd4, 3'd4, 3'd1}, 0, 0};
    vecs[1] = '{1, 12'hFFF, 0, {3'd7, 3'd7, 3'd7, 3'd7}, 0, 0};
    vecs[2] = '{0, 12'h000, 1, {3'd0, 3'd0, 3'd0, 3'd0}, 1, 4};
    vecs[3] = '{1, 12'hA5C, 0, {3'd5, 3'd1, 3'd3, 3'd4}, 0, 0};
    vecs[4] = '{1, 12'h123, 1, {3'd0, 3'd4, 3'd4, 3'd3}, 1, 4};
    vecs[5] = '{0, 12'h7B2, 0, {3'd3, 3'd6, 3'd6, 3'd2}, 0, 0};

    repeat (3) @(posedge clock);
    #1 reset_n = 1; sched_en = 1;

    foreach (vecs[i]) begin
      send_word(vecs[i].which, vecs[i].data, vecs[i].corrupt, 0, 0, r);
      chk("tbl_wait", 64'(r.wait_c), 64'd0);
      chk("tbl_latency", 64'(r.lat), 64'(2 * CHUNKS + 1));
      chk("tbl_src", 64'(r.src), 64'(vecs[i].which));
      chk("tbl_err", 64'(r.err), 64'(vecs[i].exp_err));
      chk("tbl_chunks", 64'(r.chunks), 64'(vecs[i].exp_chunks));
      chk("tbl_mis_delta", 64'(r.mis_end - r.mis_start), 64'(vecs[i].exp_mis_d));
      chk("tbl_ftf", 64'(r.ftf_end), 64'd0);
    end

    // Both requesters valid from reset: strict alternation, back-to-back words.
    reset_n = 0;
    req0_valid = 1; req0_data = 12'h555; req1_valid = 1; req1_data = 12'hAAA;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    ng = 0; nd = 0;
    for (int c = 0; c < 80 && nd < 4; c++) begin
      @(negedge clock);
      if ((req0_ready || req1_ready) && ng < 4) begin gsrc[ng] = req1_ready; rcyc[ng] = c; ng++; end
      if (word_done) begin dsrc[nd] = word_src; dcyc[nd] = c; nd++; end
      @(posedge clock); #1;
    end
    req0_valid = 0; req1_valid = 0;
    chk("alt_done_cnt", 64'(nd), 64'd4);
    chk("alt_grant_cnt", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) chk("alt_grant_src", 64'(gsrc[i]), 64'(i % 2));
      if (i < nd) chk("alt_done_src", 64'(dsrc[i]), 64'(i % 2));
      if (i < 3 && i + 1 < ng && i < nd) chk("alt_gap", 64'(rcyc[i+1]), 64'(dcyc[i] + 1));
    end

    // Forbidden codeword on the second check only.
    clear_counts();
    send_word(0, 12'h246, 0, 2, 0, r);
    chk("ftf_word_err", 64'(r.err), 64'd1);
    chk("ftf_count_one", 64'(r.ftf_end), 64'd1);
    send_word(1, 12'h135, 0, 0, 0, r);
    chk("ftf_next_err", 64'(r.err), 64'd0);
    chk("ftf_count_keep", 64'(r.ftf_end), 64'd1);

    // Clear in the same cycle as a counted mismatch wins.
    send_word(0, 12'h0F0, 1, 0, 1, r);
    chk("clr_priority", 64'(r.mis_after_clr), 64'd0);
    chk("clr_then_count", 64'(r.mis_end), 64'd3);
    chk("clr_ftf", 64'(r.ftf_end), 64'd0);
    chk("clr_word_err", 64'(r.err), 64'd1);

    // Saturation on the narrow-counter instance.
    clear_counts();
    for (int w = 0; w < 3; w++) begin
      send_word(w % 2, 12'h9C4 + 12'(w), 1, 0, 0, r);
      if (w >= 1) chk("sat_at_max", 64'(s_mis), 64'd7);
    end
    chk("wide_mis_12", 64'(mis_count), 64'd12);

    // Reset during SEND of chunk index 2: word lost, req1 granted first after release.
    req0_valid = 1; req0_data = 12'h777;
    begin
      bit acc;
      acc = 0;
      for (int i = 0; i < 20 && !acc; i++) begin
        @(negedge clock);
        acc = req0_ready;
        @(posedge clock); #1;
      end
      chk("rst_seq_accept", 64'(acc), 64'd1);
    end
    req0_valid = 0;
    repeat (4) begin @(posedge clock); #1; end
    chk("rst_seq_in_send", 64'(coder_en), 64'd1);
    reset_n = 0;
    #1;
    chk("rst_immediate", 64'({coder_en, busy, word_done, coder_data}), 64'd0);
    req1_valid = 1; req1_data = 12'h5A5;
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    send_word(1, 12'h5A5, 0, 0, 0, r);
    chk("rst_req1_first", 64'(r.wait_c), 64'd0);
    chk("rst_req1_src", 64'(r.src), 64'd1);
    chk("rst_req1_lat", 64'(r.lat), 64'(2 * CHUNKS + 1));

    // Random traffic against the reference model.
    m_words = 0;
    for (int c = 0; c < 3000; c++) begin
      req0_valid  = ($urandom % 3) != 0;
      req1_valid  = ($urandom % 3) != 0;
      req0_data   = 12'($urandom);
      req1_data   = 12'($urandom);
      sched_en    = ($urandom % 8) != 0;
      dec_bad     = ($urandom % 4) == 0;
      tsv_ovr     = ($urandom % 5) == 0;
      tsv_ovr_val = 4'($urandom);
      cnt_clr     = ($urandom % 60) == 0;
      @(posedge clock); #1;
    end
    req0_valid = 0; req1_valid = 0; dec_bad = 0; tsv_ovr = 0; cnt_clr = 0;
    repeat (12) @(posedge clock);
    chk("rand_words_seen", 64'(m_words > 50), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1_000_000;
    n_mis++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cac_link_scheduler.md
Name: cac_link_scheduler

Overview:
Shares one CAC coder/decoder TSV channel (Fibonacci-numeral-system, forbidden-transition-free code) between two requesters. Round-robin arbitration; each granted word is sliced into BLEN-bit chunks, and each chunk is strobed into the registered coder. After every strobe the TSV codeword is checked for forbidden patterns and the decoder output is compared against the chunk sent. Per-word status and running error counters are reported.

Parameters:
BLEN, 3, chunk width = coder data width.
TSV_W, 4, coder TSV output width.
CHUNKS, 4, chunks per word; WORD_W = BLEN*CHUNKS.
CNT_W, 16, width of the error counters.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
sched_en  in  1  1 = new grants allowed.
cnt_clr  in  1  synchronous clear of both counters.
req0_valid, req1_valid  in  1 each  requester has a word.
req0_data, req1_data  in  WORD_W each  word to transmit.
req0_ready, req1_ready  out  1 each  accept strobe; the word is taken in this cycle.
coder_data  out  BLEN  chunk driven to the coder.
coder_en  out  1  one-cycle coder clock-enable per chunk.
tsv  in  TSV_W  coder codeword, registered by the coder.
dec_data  in  BLEN  decoder output, combinational from tsv.
busy  out  1  FSM not in IDLE.
word_done  out  1  one-cycle pulse when a word completes.
word_src  out  1  requester index of the completed word; valid with word_done.
word_err  out  1  1 = the completed word had any FTF violation or mismatch.
ftf_count  out  CNT_W  saturating count of FTF-violating codewords.
mis_count  out  CNT_W  saturating count of chunk mismatches.

Behaviour:
- Reset (async, active-low) sets every output to 0, FSM to IDLE, rr_ptr to 0 and chunk_idx to 0, and discards any latched word.
- Reset released mid-word: the word is lost, no word_done is issued, and the requester is not re-granted.
- FSM states: IDLE, SEND, CHECK, DONE.
- IDLE, sched_en=1 with any valid:
  - Grant order: requester rr_ptr if it is valid, else the other.
  - Assert the granted reqN_ready combinationally in this cycle.
  - Latch the data and src, clear word_err_acc, set chunk_idx=0, go to SEND.
- IDLE, sched_en=0: no grant and no ready. Deasserting sched_en mid-word does not abort the word.
- SEND: coder_data = word[chunk_idx*BLEN +: BLEN] (LSB chunk first), coder_en=1 for exactly this cycle. Go to CHECK.
- coder_data holds its last value when coder_en=0.
- CHECK: sample tsv and dec_data.
  - FTF violation if, for any j in 1..TSV_W-1: odd j with tsv[j]=0 and tsv[j-1]=1; even j with tsv[j]=1 and tsv[j-1]=0.
  - Mismatch if dec_data != sent chunk.
  - Each condition increments its counter by 1 and sets word_err_acc.
  - If chunk_idx=CHUNKS-1 go to DONE; else chunk_idx++ and go to SEND.
- DONE: word_done=1, word_src=latched src, word_err=word_err_acc. rr_ptr = ~src. Go to IDLE.
- Latency: accept in cycle 0; coder_en in cycles 1,3,...,2*CHUNKS-1; word_done in cycle 2*CHUNKS+1. Default: cycle 9.
- Throughput: the next grant can occur in the cycle after DONE, i.e. one word per 2*CHUNKS+2 cycles.
- Counters saturate at 2^CNT_W-1 and never wrap.
- cnt_clr has priority over an increment in the same cycle; the result is 0.
- cnt_clr does not affect word_err_acc.
- Simultaneous valid on both requesters: rr_ptr wins. The loser's valid stays and is granted next.
- req valid dropped while not granted: no effect.

Test Plan:
- Reset, then req0_valid=1 with data 12'h321, req1 idle: req0_ready pulses cycle 0; coder_data = 1,4,4,1 (3-bit chunks LSB-first) with coder_en in cycles 1,3,5,7; word_done in cycle 9 with src=0, err=0; counters 0.
- Both valid continuously from reset: grants alternate 0,1,0,1; no word_done is lost; the idle gap between done and the next ready is 0 cycles.
- Force tsv=4'b0101 in the 2nd CHECK only: ftf_count=1 and word_err=1 for that word; the next word has err=0.
- Force dec_data=coder_data^3'b001 on every chunk: mis_count +4 per word; after the counter is preloaded near max it saturates at 16'hFFFF.
- Assert cnt_clr in the same cycle as a counted violation: counter reads 0 the next cycle.
- Pull reset_n low in the SEND of chunk 2: all outputs 0 immediately, no word_done; after release with req1 valid, req1 is granted first (rr_ptr=0 only if req0 is valid).
